// File: rtl/serial_alu_ext.sv
// Bit-serial ALU: one extender/full-adder slice reused over WIDTH cycles, LSB first.
// Produces a WIDTH-bit arithmetic or logic result plus carry/overflow/zero flags.
module serial_alu_ext #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             M,
   input  logic             s1,
   input  logic             s0,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   // Handshake: start is accepted on a rising edge only while busy=0; busy is high
   // from the following cycle for exactly WIDTH cycles; done pulses for one cycle
   // when result/flags update, and start may be accepted in that same cycle.

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SHIFT = 1'b1;

   logic [0:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic             m_q;
   logic [1:0]       sel_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic             x_bit;
   logic             b_bit;
   logic             y_bit;
   logic             sum_bit;
   logic             carry_nxt;
   logic             carry_init;
   logic [WIDTH-1:0] acc_nxt;

   // Arithmetic modes start with carry 1 for A-B and A+1, 0 otherwise; logic mode never carries.
   assign carry_init = ~M & (s1 ^ s0);

   // Single extender + full-adder slice operating on the current LSB of the operand shifters.
   always_comb begin
      x_bit     = a_q[0];
      b_bit     = b_q[0];
      y_bit     = 1'b0;
      sum_bit   = 1'b0;
      carry_nxt = 1'b0;
      if (m_q) begin
         case (sel_q)
            2'b00:   sum_bit = x_bit & b_bit;
            2'b01:   sum_bit = x_bit | b_bit;
            2'b10:   sum_bit = x_bit ^ b_bit;
            default: sum_bit = ~x_bit;
         endcase
      end else begin
         case (sel_q)
            2'b00:   y_bit = b_bit;
            2'b01:   y_bit = ~b_bit;
            2'b10:   y_bit = 1'b0;
            default: y_bit = 1'b1;
         endcase
         sum_bit   = x_bit ^ y_bit ^ carry_q;
         carry_nxt = (x_bit & y_bit) | (x_bit & carry_q) | (y_bit & carry_q);
      end
   end

   assign acc_nxt = {sum_bit, acc_q[WIDTH-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         m_q     <= 1'b0;
         sel_q   <= 2'b00;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  m_q     <= M;
                  sel_q   <= {s1, s0};
                  carry_q <= carry_init;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               acc_q   <= acc_nxt;
               carry_q <= carry_nxt;
               if (cnt_q == LAST) begin
                  // carry_q here is the carry into the MSB, carry_nxt the carry out of it.
                  result <= acc_nxt;
                  cout   <= carry_nxt;
                  ovf    <= carry_q ^ carry_nxt;
                  zero   <= (acc_nxt == '0);
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  cnt_q  <= '0;
                  state  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_alu_ext.sv
// Directed bench for serial_alu_ext (WIDTH=8): table of hand-computed operations
// plus sequences for busy-start, back-to-back start and mid-operation reset.
module tb_serial_alu_ext;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         M;
   logic         s1;
   logic         s0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         zero;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic         m;
      logic [1:0]   sel;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
      logic         z;
   } vec_t;

   vec_t vecs[12];

   serial_alu_ext #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .M      (M),
      .s1     (s1),
      .s0     (s0),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf),
      .zero   (zero)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1, "time limit");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // driver: called at a negedge; returns at the negedge after the accepting edge
   task automatic start_op(input logic m_i, input logic [1:0] s_i,
                           input logic [W-1:0] a_i, input logic [W-1:0] b_i);
      M     = m_i;
      s1    = s_i[1];
      s0    = s_i[0];
      a     = a_i;
      b     = b_i;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 3 * W) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_out(input string p, input logic [W-1:0] r, input logic co,
                            input logic ov, input logic z);
      check({p, "_result"}, 32'(result), 32'(r));
      check({p, "_cout"},   32'(cout),   32'(co));
      check({p, "_ovf"},    32'(ovf),    32'(ov));
      check({p, "_zero"},   32'(zero),   32'(z));
   endtask

   initial begin
      int n;
      int pulses;
      string p;

      //           m     sel    a      b      res    co    ov    z
      vecs[0]  = '{1'b0, 2'b00, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b0, 2'b01, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 2'b11, 8'h00, 8'h05, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 2'b10, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 2'b00, 8'hCA, 8'hA5, 8'h80, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 2'b01, 8'hCA, 8'hA5, 8'hEF, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 2'b10, 8'hCA, 8'hA5, 8'h6F, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 2'b11, 8'hCA, 8'hA5, 8'h35, 1'b0, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 2'b01, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 2'b00, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 2'b00, 8'h0F, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 2'b01, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};

      rst = 1'b1; start = 1'b0; a = '0; b = '0; M = 1'b0; s1 = 1'b0; s0 = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // table-driven operations; from the second one on, start lands in the done cycle
      for (int i = 0; i < 12; i++) begin
         p = $sformatf("vec%0d", i);
         start_op(vecs[i].m, vecs[i].sel, vecs[i].a, vecs[i].b);
         check({p, "_busy"}, 32'(busy), 1);
         check({p, "_done_low"}, 32'(done), 0);
         wait_done(n);
         check({p, "_latency"}, 32'(n), W);
         check_out(p, vecs[i].res, vecs[i].co, vecs[i].ov, vecs[i].z);
      end
      @(negedge clk);
      check("idle_done", 32'(done), 0);
      check("idle_busy", 32'(busy), 0);
      check_out("idle_hold", 8'h7F, 1'b1, 1'b1, 1'b0);

      // start while busy and operand changes during SHIFT are ignored
      start_op(1'b0, 2'b00, 8'h11, 8'h22);
      n = 0;
      while (!done && n < 3 * W) begin
         if (n == 2) begin
            start = 1'b1; M = 1'b1; s1 = 1'b1; s0 = 1'b1; a = 8'hFF; b = 8'hFF;
         end else begin
            start = 1'b0; a = 8'h5A; b = 8'hA5; M = 1'b0; s1 = 1'b0; s0 = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check("busy_start_latency", 32'(n), W);
      check_out("busy_start", 8'h33, 1'b0, 1'b0, 1'b0);

      // back-to-back: accepted in done cycle, done drops, second result on time
      start_op(1'b0, 2'b00, 8'h90, 8'h90);
      check("b2b_done_drop", 32'(done), 0);
      check("b2b_busy", 32'(busy), 1);
      wait_done(n);
      check("b2b_latency", 32'(n), W);
      check_out("b2b", 8'h20, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("b2b_pulse_width", 32'(done), 0);

      // reset three cycles into an A+B
      start_op(1'b0, 2'b00, 8'h55, 8'h0A);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_mid_busy", 32'(busy), 0);
      check("rst_mid_done", 32'(done), 0);
      check_out("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 2 * W; i++) begin
         @(negedge clk);
         if (done || busy) pulses++;
      end
      check("rst_no_done", 32'(pulses), 0);

      start_op(1'b0, 2'b00, 8'h10, 8'h20);
      wait_done(n);
      check("post_rst_latency", 32'(n), W);
      check_out("post_rst", 8'h30, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
